decoder4_hold: RTL and testbench
================================

# decoder4_hold

Sequential 2-to-4 one-hot decoder, the receive-side counterpart of the 4-to-2 encoder in the Encoders-Decoders library. It accepts 2-bit codes through a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. It then returns the output to zero. It sits after an encoder or any code source that needs a stretched, glitch-free one-hot strobe.

## Interface
- HOLD_CYCLES, 4: cycles each decoded one-hot word stays asserted; legal range 1..255.
- CW, 8: hold-counter width; must satisfy 2^CW > HOLD_CYCLES.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- clr  input  1  synchronous abort; ends any hold in progress.
- in_code  input  2  code to decode (0..3).
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block accepts in_code this cycle.
- out  output  4  one-hot decode (code k -> bit k); 4'b0000 when idle.
- out_valid  output  1  out holds a decoded word.

## Operation
- Accept event: in_valid && in_ready at a rising edge; in_code is captured.
- FSM states:
  - IDLE: out=0, out_valid=0, in_ready=1.
  - HOLD: out=1<<code, out_valid=1.
- IDLE -> HOLD on accept; the counter loads HOLD_CYCLES-1.
- HOLD with counter>0: counter decrements, in_ready=0.
- HOLD with counter==0 (last cycle): in_ready=1.
  - If accept: reload the new code and counter, stay in HOLD (back-to-back, no gap cycle).
  - Else: go to IDLE.
- in_ready = !clr && (state==IDLE || counter==0). It is combinational from state, counter and clr only, never from in_valid.
- clr=1: next state IDLE, counter 0, out=0, out_valid=0. No accept occurs in that cycle, because in_ready is 0.
- rst has priority over clr and over accept.
- in_code is decoded from the captured register only. Changes on in_code while not accepting have no effect.
- in_code containing X/Z at accept: out goes to 4'bxxxx for that hold, matching the encoder's default-x convention. Not a synthesis concern.
- Counter is CW bits wide. It never wraps, because it is loaded at most with HOLD_CYCLES-1 and stops at 0.

## Timing
- Reset values: out=4'b0000, out_valid=0, state IDLE, counter 0. in_ready=1 in the first cycle after reset (when clr=0).
- Latency:
  - Accept at edge N -> out/out_valid asserted from edge N (registered output, visible in cycle N+1).
  - Asserted for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: in_ready stays 1 throughout, so one code can be accepted per cycle.
- Throughput: one code per HOLD_CYCLES cycles sustained.
- rst or clr asserted mid-hold: out and out_valid are 0 in the cycle after the edge.

## Configuration
- DEC4_PIPE_EN defined:
  - Adds one output register stage, so out and out_valid lag the internal FSM by one cycle (latency +1).
  - in_ready timing is unchanged.
  - clr and rst also zero the pipe stage, so out=0 one cycle after the edge.
- DEC4_PIPE_EN undefined: outputs come directly from the FSM registers as described above.

## Test plan
- Reset, then in_code=2, in_valid=1 for 1 cycle, HOLD_CYCLES=4 -> out=4'b0100 and out_valid=1 for exactly 4 cycles, then out=0. in_ready is 0 for the first 3 of those cycles.
- Back-to-back: codes 0,1,3 with in_valid held high -> out=0001,0010,1000, each for 4 cycles, with no zero cycle between them.
- in_valid=1 with code=1 during the 2nd hold cycle of code 3 -> ignored. out stays 4'b1000, and code 1 is accepted only on the last hold cycle.
- clr pulse in the 2nd hold cycle of code 0 with in_valid=1 -> out=0 and out_valid=0 next cycle. The input is not accepted while clr=1 and is accepted the cycle after.
- rst asserted mid-hold together with an accept -> out=0, out_valid=0, in_ready=1 after the edge; the code is not decoded.
- HOLD_CYCLES=1 with DEC4_PIPE_EN, codes 0..3 on consecutive cycles -> out=0001,0010,0100,1000 on 4 consecutive cycles, each one cycle later than in the non-pipelined build.

Source files
------------

// File: rtl/decoder4_hold.sv
// rtl/decoder4_hold.sv - 2-to-4 one-hot decoder that holds each decoded word for HOLD_CYCLES cycles
// Optional feature macro: DEC4_PIPE_EN (adds one output register stage; in_ready timing unchanged)
module decoder4_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out,
  output logic       out_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    word, word_n;
  logic          word_valid, word_valid_n;
  logic          accept;

  // Unknown codes decode to all-x so a bad source is visible downstream.
  function automatic logic [3:0] decode(input logic [1:0] code);
    case (code)
      2'd0:    decode = 4'b0001;
      2'd1:    decode = 4'b0010;
      2'd2:    decode = 4'b0100;
      2'd3:    decode = 4'b1000;
      default: decode = 4'bxxxx;
    endcase
  endfunction

  // Ready depends only on state, counter and clr so it never loops back through in_valid.
  always_comb begin
    in_ready = !clr && (state == IDLE || cnt == '0);
    accept   = in_valid && in_ready;
  end

  // Next-state logic: clr aborts, otherwise load on accept or count down the hold.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    word_n       = word;
    word_valid_n = word_valid;
    if (clr) begin
      state_n      = IDLE;
      cnt_n        = '0;
      word_n       = 4'b0000;
      word_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_n      = HOLD;
            cnt_n        = CW'(HOLD_CYCLES - 1);
            word_n       = decode(in_code);
            word_valid_n = 1'b1;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else if (accept) begin
            cnt_n        = CW'(HOLD_CYCLES - 1);
            word_n       = decode(in_code);
            word_valid_n = 1'b1;
          end else begin
            state_n      = IDLE;
            word_n       = 4'b0000;
            word_valid_n = 1'b0;
          end
        end
        default: begin
          state_n      = IDLE;
          cnt_n        = '0;
          word_n       = 4'b0000;
          word_valid_n = 1'b0;
        end
      endcase
    end
  end

  // FSM registers; rst wins over clr and over any accept in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      word       <= 4'b0000;
      word_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      word       <= word_n;
      word_valid <= word_valid_n;
    end
  end

`ifdef DEC4_PIPE_EN
  logic [3:0] out_p;
  logic       out_valid_p;

  // Extra output stage; rst and clr flush it so the strobe drops one cycle after either.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out_p       <= 4'b0000;
      out_valid_p <= 1'b0;
    end else begin
      out_p       <= word;
      out_valid_p <= word_valid;
    end
  end

  assign out       = out_p;
  assign out_valid = out_valid_p;
`else
  assign out       = word;
  assign out_valid = word_valid;
`endif

endmodule

// File: tb/tb_decoder4_hold.sv
// tb/tb_decoder4_hold.sv - scoreboard bench for decoder4_hold at HOLD_CYCLES=4 and HOLD_CYCLES=1
module tb_decoder4_hold;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid;
  logic [1:0] in_code;
  logic       rdy0, rdy1, ov0, ov1;
  logic [3:0] o0, o1;

  int total = 0;
  int bad   = 0;

  // Reference state per instance: rem = cycles of hold left including the current one (0 = idle).
  int         hc[2]  = '{4, 1};
  int         rem[2] = '{0, 0};
  logic [1:0] mcode[2];
  logic [4:0] pipe[2] = '{5'b0, 5'b0};
  logic [4:0] sb0[$];
  logic [4:0] sb1[$];

  always #5 clk = ~clk;

  decoder4_hold #(.HOLD_CYCLES(4), .CW(8)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in_code(in_code), .in_valid(in_valid),
    .in_ready(rdy0), .out(o0), .out_valid(ov0)
  );

  decoder4_hold #(.HOLD_CYCLES(1), .CW(2)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_code(in_code), .in_valid(in_valid),
    .in_ready(rdy1), .out(o1), .out_valid(ov1)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] fsm_view(input int i);
    logic [3:0] one;
    one = 4'b0001 << mcode[i];
    return (rem[i] > 0) ? {1'b1, one} : 5'b00000;
  endfunction

  // One clock cycle: check outputs of the last edge, drive inputs, check ready, predict next edge.
  task automatic step(input logic r, input logic c, input logic [1:0] code, input logic v);
    logic [4:0] e;
    logic [4:0] prev;
    logic       rdy_e, rdy_o, acc, live;
    live = (sb0.size() > 0);
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      chk("out_h4", {ov0, o0}, e);
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      chk("out_h1", {ov1, o1}, e);
    end
    rst      = r;
    clr      = c;
    in_code  = code;
    in_valid = v;
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy_e = !c && (rem[i] <= 1);
      rdy_o = (i == 0) ? rdy0 : rdy1;
      if (live) chk($sformatf("ready_h%0d", hc[i]), {4'b0000, rdy_o}, {4'b0000, rdy_e});
      acc  = v && rdy_e && !r;
      prev = fsm_view(i);
      if (r || c)       rem[i] = 0;
      else if (acc) begin
        rem[i]   = hc[i];
        mcode[i] = code;
      end
      else if (rem[i] > 0) rem[i] = rem[i] - 1;
`ifdef DEC4_PIPE_EN
      pipe[i] = (r || c) ? 5'b00000 : prev;
      e = pipe[i];
`else
      e = fsm_view(i);
`endif
      if (i == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // reset, then idle with ready high
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // single code 2, held then released
    step(0, 0, 2, 1);
    repeat (6) step(0, 0, 2, 0);
    // back-to-back 0,1,3 with valid held high
    repeat (4) step(0, 0, 0, 1);
    repeat (4) step(0, 0, 1, 1);
    repeat (2) step(0, 0, 3, 1);
    // code 1 offered during 2nd hold cycle of 3 is ignored; taken on last hold cycle
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    repeat (6) step(0, 0, 0, 0);
    // clr in 2nd hold cycle of code 0 with valid high
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 2, 1);
    step(0, 0, 2, 1);
    repeat (5) step(0, 0, 0, 0);
    // rst on the last hold cycle together with an offered code
    step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 3, 1);
    repeat (2) step(0, 0, 0, 0);
    // codes 0..3 on consecutive cycles
    for (int k = 0; k < 4; k++) step(0, 0, 2'(k), 1);
    repeat (5) step(0, 0, 0, 0);
    // random mix
    for (int k = 0; k < 60; k++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
           2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
    repeat (3) step(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
